// File: rtl/alu_req_sequencer_pkg.sv
// alu_req_sequencer_pkg: opcodes, FSM states and default width shared by the ALU sequencer
package alu_req_sequencer_pkg;
   localparam int DATA_W_DEF = 8;
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_NOR = 3'b011;
   localparam logic [2:0] OP_SHL = 3'b100;
   localparam logic [2:0] OP_SHR = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;
endpackage

// File: rtl/alu_core8.sv
// alu_core8: combinational single-cycle ALU ops; MUL is handled by the sequencer and yields 0 here
module alu_core8
   import alu_req_sequencer_pkg::*;
#(
   parameter int W = DATA_W_DEF
) (
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y,
   output logic         flag
);
   logic [W:0] sum, dif;
   assign sum = {1'b0, a} + {1'b0, b};
   assign dif = {1'b0, a} - {1'b0, b};
   always_comb begin
      y = '0;
      flag = 1'b0;
      case (op)
         OP_ADD:  {flag, y} = sum;
         OP_OR:   y = a | b;
         OP_AND:  y = a & b;
         OP_NOR:  y = ~(a | b);
         OP_SHL:  y = a << b[2:0];
         OP_SHR:  y = a >> b[2:0];
         OP_SUB:  {flag, y} = dif;
         default: y = '0;
      endcase
   end
endmodule

// File: rtl/alu_req_sequencer.sv
// alu_req_sequencer: round-robin shares one ALU between two requesters, with an iterative shift-add MUL
module alu_req_sequencer
   import alu_req_sequencer_pkg::*;
#(
   parameter int   DATA_W   = DATA_W_DEF,
   parameter int   MUL_ITER = 8,
   parameter logic RR_INIT  = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [2:0]        req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [2:0]        req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_y,
   output logic              rsp_flag,
   output logic              busy
);
   state_t state;
   logic last_grant, grant, accept, id_q;
   logic [2:0] op_q, sel_op, cnt;
   logic [DATA_W-1:0] a_q, b_q, mplier, sel_a, sel_b, alu_y;
   logic alu_flag;
   logic [2*DATA_W-1:0] prod, prod_nx;
   // a tie goes to whoever did not win last; a lone requester always wins
   assign grant = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
   assign req0_ready = rst_n & ena & (state == S_IDLE) & req0_valid & ~grant;
   assign req1_ready = rst_n & ena & (state == S_IDLE) & req1_valid & grant;
   assign accept = req0_ready | req1_ready;
   assign sel_op = grant ? req1_op : req0_op;
   assign sel_a = grant ? req1_a : req0_a;
   assign sel_b = grant ? req1_b : req0_b;
   assign busy = state != S_IDLE;
   assign prod_nx = prod + (mplier[0] ? ({{DATA_W{1'b0}}, a_q} << cnt) : '0);
   alu_core8 #(.W(DATA_W)) u_core (
      .op(op_q),
      .a(a_q),
      .b(b_q),
      .y(alu_y),
      .flag(alu_flag)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         last_grant <= RR_INIT;
         id_q <= 1'b0;
         op_q <= '0;
         a_q <= '0;
         b_q <= '0;
         mplier <= '0;
         prod <= '0;
         cnt <= '0;
         rsp_valid <= 1'b0;
         rsp_id <= 1'b0;
         rsp_y <= '0;
         rsp_flag <= 1'b0;
      end else if (ena) begin
         case (state)
            S_IDLE: if (accept) begin
               op_q <= sel_op;
               a_q <= sel_a;
               b_q <= sel_b;
               mplier <= sel_b;
               prod <= '0;
               cnt <= '0;
               id_q <= grant;
               last_grant <= grant;
               if (sel_op == OP_MUL) state <= S_MUL;
               else state <= S_EXEC;
            end
            S_EXEC: begin
               rsp_y <= alu_y;
               rsp_flag <= alu_flag;
               rsp_id <= id_q;
               rsp_valid <= 1'b1;
               state <= S_RESP;
            end
            S_MUL: begin
               prod <= prod_nx;
               mplier <= mplier >> 1;
               cnt <= cnt + 3'd1;
               if (cnt == 3'(MUL_ITER - 1)) begin
                  rsp_y <= prod_nx[DATA_W-1:0];
                  rsp_flag <= |prod_nx[2*DATA_W-1:DATA_W];
                  rsp_id <= id_q;
                  rsp_valid <= 1'b1;
                  state <= S_RESP;
               end
            end
            default: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_req_sequencer.sv
// tb_alu_req_sequencer: directed, hand-computed checks of arbitration, ALU ops, MUL timing, stalls, reset and enable
module tb_alu_req_sequencer;
   logic clk, rst_n, ena, rsp_ready;
   logic req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0] req0_op, req1_op;
   logic [7:0] req0_a, req0_b, req1_a, req1_b, rsp_y;
   logic rsp_valid, rsp_id, rsp_flag, busy;
   int n_chk = 0;
   int n_fail = 0;
   alu_req_sequencer dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_flag(rsp_flag),
      .busy(busy)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic rsp_is(input string tag, input logic id, input logic [7:0] y, input logic flag);
      chk({tag, ".valid"}, 16'(rsp_valid), 16'h1);
      chk({tag, ".id"}, 16'(rsp_id), 16'(id));
      chk({tag, ".y"}, 16'(rsp_y), 16'(y));
      chk({tag, ".flag"}, 16'(rsp_flag), 16'(flag));
   endtask
   // drive one command at a negedge, confirm it is granted, return at the negedge after the accept edge
   task automatic send(input string tag, input int r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      if (r == 0) begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end
      #1;
      chk({tag, ".ready"}, 16'(r == 0 ? req0_ready : req1_ready), 16'h1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      rst_n = 1'b0; ena = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 3'b000; req0_a = 8'h00; req0_b = 8'h00;
      req1_valid = 1'b1; req1_op = 3'b000; req1_a = 8'h00; req1_b = 8'h00;
      @(negedge clk);
      chk("reset.rsp_valid", 16'(rsp_valid), 16'h0);
      chk("reset.busy", 16'(busy), 16'h0);
      chk("reset.ready0", 16'(req0_ready), 16'h0);
      chk("reset.ready1", 16'(req1_ready), 16'h0);
      chk("reset.y", 16'(rsp_y), 16'h0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      // T1 ADD with carry
      send("t1", 0, 3'b000, 8'hF0, 8'h20);
      chk("t1.exec_busy", 16'(busy), 16'h1);
      chk("t1.exec_valid", 16'(rsp_valid), 16'h0);
      @(negedge clk);
      rsp_is("t1.rsp", 1'b0, 8'h10, 1'b1);
      chk("t1.resp_busy", 16'(busy), 16'h1);
      @(negedge clk);
      chk("t1.done_valid", 16'(rsp_valid), 16'h0);
      chk("t1.done_busy", 16'(busy), 16'h0);
      // T2 round-robin from reset
      do_reset();
      req1_valid = 1'b1; req1_op = 3'b001; req1_a = 8'h0F; req1_b = 8'hF0;
      send("t2.sub", 0, 3'b110, 8'h05, 8'h07);
      req1_valid = 1'b1;
      #1 chk("t2.exec_ready1", 16'(req1_ready), 16'h0);
      @(negedge clk);
      rsp_is("t2.sub_rsp", 1'b0, 8'hFE, 1'b1);
      chk("t2.resp_ready1", 16'(req1_ready), 16'h0);
      @(negedge clk);
      send("t2.or", 1, 3'b001, 8'h0F, 8'hF0);
      @(negedge clk);
      rsp_is("t2.or_rsp", 1'b1, 8'hFF, 1'b0);
      @(negedge clk);
      req1_valid = 1'b1; req1_op = 3'b011; req1_a = 8'h00; req1_b = 8'h00;
      req0_valid = 1'b1;
      #1 chk("t2.tie_ready1", 16'(req1_ready), 16'h0);
      send("t2.and", 0, 3'b010, 8'hFF, 8'h3C);
      req1_valid = 1'b1;
      @(negedge clk);
      rsp_is("t2.and_rsp", 1'b0, 8'h3C, 1'b0);
      @(negedge clk);
      send("t2.nor", 1, 3'b011, 8'h00, 8'h00);
      @(negedge clk);
      rsp_is("t2.nor_rsp", 1'b1, 8'hFF, 1'b0);
      @(negedge clk);
      // T3 MUL latency and results
      send("t3.m1", 0, 3'b111, 8'h0D, 8'h0B);
      for (int i = 0; i < 8; i++) begin
         chk("t3.m1_wait", 16'(rsp_valid), 16'h0);
         @(negedge clk);
      end
      rsp_is("t3.m1_rsp", 1'b0, 8'h8F, 1'b0);
      @(negedge clk);
      send("t3.m2", 1, 3'b111, 8'h20, 8'h10);
      for (int i = 0; i < 8; i++) begin
         chk("t3.m2_wait", 16'(rsp_valid), 16'h0);
         @(negedge clk);
      end
      rsp_is("t3.m2_rsp", 1'b1, 8'h00, 1'b1);
      @(negedge clk);
      // T4 response back-pressure
      rsp_ready = 1'b0;
      send("t4.and", 1, 3'b010, 8'hF0, 8'h3C);
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 3'b000; req0_a = 8'h01; req0_b = 8'h02;
      req1_valid = 1'b1; req1_op = 3'b001; req1_a = 8'h55; req1_b = 8'h00;
      for (int i = 0; i < 5; i++) begin
         rsp_is("t4.hold", 1'b1, 8'h30, 1'b0);
         chk("t4.ready0", 16'(req0_ready), 16'h0);
         chk("t4.ready1", 16'(req1_ready), 16'h0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1 chk("t4.hs_ready0", 16'(req0_ready), 16'h0);
      @(negedge clk);
      chk("t4.after_valid", 16'(rsp_valid), 16'h0);
      send("t4.add", 0, 3'b000, 8'h01, 8'h02);
      @(negedge clk);
      rsp_is("t4.add_rsp", 1'b0, 8'h03, 1'b0);
      @(negedge clk);
      // T5 reset mid-MUL
      send("t5.mul", 0, 3'b111, 8'hFF, 8'hFF);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5.rst_valid", 16'(rsp_valid), 16'h0);
      chk("t5.rst_busy", 16'(busy), 16'h0);
      chk("t5.rst_y", 16'(rsp_y), 16'h0);
      chk("t5.rst_flag", 16'(rsp_flag), 16'h0);
      chk("t5.rst_id", 16'(rsp_id), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t5.no_stale", 16'(rsp_valid), 16'h0);
      end
      send("t5.shr", 1, 3'b101, 8'h80, 8'h03);
      @(negedge clk);
      rsp_is("t5.shr_rsp", 1'b1, 8'h10, 1'b0);
      @(negedge clk);
      // T6 enable low during EXEC
      send("t6.shl", 0, 3'b100, 8'h81, 8'h01);
      ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6.hold_valid", 16'(rsp_valid), 16'h0);
         chk("t6.hold_busy", 16'(busy), 16'h1);
         chk("t6.hold_y", 16'(rsp_y), 16'h10);
      end
      ena = 1'b1;
      @(negedge clk);
      rsp_is("t6.shl_rsp", 1'b0, 8'h02, 1'b0);
      @(negedge clk);
      chk("t6.idle", 16'(busy), 16'h0);
      ena = 1'b0; req0_valid = 1'b1;
      #1 chk("t6.ena_low_ready", 16'(req0_ready), 16'h0);
      req0_valid = 1'b0; ena = 1'b1;
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
